// File: rtl/alu_seq.sv
// Sequential N-bit ALU: one operation per start strobe, registered result and NZCV flags,
// single-cycle logic/arith/shift ops and an iterative N-cycle shift-add multiplier.
module alu_seq #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] y,
    output logic         flag_n,
    output logic         flag_z,
    output logic         flag_c,
    output logic         flag_v,
    output logic         busy,
    output logic         done
);

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_XOR = 3'b010,
        OP_ADD = 3'b011,
        OP_SUB = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_MUL = 3'b111
    } op_e;

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    localparam int         CW   = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    localparam logic [N:0] N_W  = (N + 1)'(N);

    state_e          state_q, state_d;
    logic [2*N-1:0]  mcand_q, mcand_d;
    logic [N-1:0]    mplier_q, mplier_d;
    logic [2*N-1:0]  acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]    y_q, y_d;
    flags_t          flags_q, flags_d;
    logic            done_q, done_d;

    op_e             op_w;
    logic [N:0]      add_w;
    logic [N:0]      sub_w;
    logic            shift_big;
    logic [N-1:0]    alu_y;
    logic            alu_c;
    logic            alu_v;
    logic [2*N-1:0]  acc_sum;
    logic            mul_last;

    assign op_w = op_e'(op);

    // Single-cycle datapath; subtraction is a + ~b + 1 so its carry means "no borrow".
    always_comb begin
        add_w     = {1'b0, a} + {1'b0, b};
        sub_w     = {1'b0, a} + {1'b0, ~b} + (N + 1)'(1);
        shift_big = ({1'b0, b} >= N_W);
        alu_y     = '0;
        alu_c     = 1'b0;
        alu_v     = 1'b0;
        case (op_w)
            OP_AND: alu_y = a & b;
            OP_OR:  alu_y = a | b;
            OP_XOR: alu_y = a ^ b;
            OP_ADD: begin
                alu_y = add_w[N-1:0];
                alu_c = add_w[N];
                alu_v = (a[N-1] == b[N-1]) && (add_w[N-1] != a[N-1]);
            end
            OP_SUB: begin
                alu_y = sub_w[N-1:0];
                alu_c = sub_w[N];
                alu_v = (a[N-1] != b[N-1]) && (sub_w[N-1] != a[N-1]);
            end
            OP_SHL: alu_y = shift_big ? '0 : (a << b);
            OP_SHR: alu_y = shift_big ? '0 : (a >> b);
            default: alu_y = '0;
        endcase
    end

    assign acc_sum  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    assign mul_last = (cnt_q == LAST);

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        y_d      = y_q;
        flags_d  = flags_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (op_w == OP_MUL) begin
                        mcand_d  = {{N{1'b0}}, a};
                        mplier_d = b;
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = S_MUL;
                    end else begin
                        y_d       = alu_y;
                        flags_d.n = alu_y[N-1];
                        flags_d.z = (alu_y == '0);
                        flags_d.c = alu_c;
                        flags_d.v = alu_v;
                        done_d    = 1'b1;
                    end
                end
            end
            S_MUL: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (mul_last) begin
                    // Result comes from this edge's accumulation, not the registered accumulator.
                    y_d       = acc_sum[N-1:0];
                    flags_d.n = acc_sum[N-1];
                    flags_d.z = (acc_sum[N-1:0] == '0);
                    flags_d.c = |acc_sum[2*N-1:N];
                    flags_d.v = 1'b0;
                    done_d    = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            y_q      <= '0;
            flags_q  <= '0;
            done_q   <= 1'b0;
            // NOTE: the multiplier datapath is reset too; it is small and a reset mid-multiply must leave nothing stale.
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            y_q      <= y_d;
            flags_q  <= flags_d;
            done_q   <= done_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    assign y      = y_q;
    assign flag_n = flags_q.n;
    assign flag_z = flags_q.z;
    assign flag_c = flags_q.c;
    assign flag_v = flags_q.v;
    assign busy   = (state_q == S_MUL);
    assign done   = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: arithmetic reference model compared every cycle,
// plus hand-computed directed expectations.
module tb_alu_seq;

    localparam int N = 4;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op    = 3'b000;
    logic [N-1:0] a     = '0;
    logic [N-1:0] b     = '0;
    logic [N-1:0] y;
    logic         flag_n, flag_z, flag_c, flag_v, busy, done;

    int total = 0;
    int bad   = 0;

    alu_seq #(.N(N)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .y      (y),
        .flag_n (flag_n),
        .flag_z (flag_z),
        .flag_c (flag_c),
        .flag_v (flag_v),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] y;
        logic         n;
        logic         z;
        logic         c;
        logic         v;
    } res_t;

    // Reference result from plain integer arithmetic.
    function automatic res_t model_op(input logic [2:0] o, input logic [N-1:0] x, input logic [N-1:0] w);
        res_t        r;
        int          ui, wi, si, ti, full, sfull;
        int          lim, smax, smin;
        logic [31:0] tmp;
        r    = '0;
        ui   = int'(x);
        wi   = int'(w);
        si   = int'($signed(x));
        ti   = int'($signed(w));
        lim  = 1 << N;
        smax = (1 << (N - 1)) - 1;
        smin = -(1 << (N - 1));
        case (o)
            3'd0: r.y = x & w;
            3'd1: r.y = x | w;
            3'd2: r.y = x ^ w;
            3'd3: begin
                full  = ui + wi;
                tmp   = full;
                r.y   = tmp[N-1:0];
                r.c   = (full >= lim);
                sfull = si + ti;
                r.v   = (sfull > smax) || (sfull < smin);
            end
            3'd4: begin
                full  = ui - wi;
                tmp   = full;
                r.y   = tmp[N-1:0];
                r.c   = (ui >= wi);
                sfull = si - ti;
                r.v   = (sfull > smax) || (sfull < smin);
            end
            3'd5: begin
                tmp = ui << wi;
                r.y = (wi >= N) ? '0 : tmp[N-1:0];
            end
            3'd6: begin
                tmp = ui >> wi;
                r.y = (wi >= N) ? '0 : tmp[N-1:0];
            end
            default: begin
                full = ui * wi;
                tmp  = full;
                r.y  = tmp[N-1:0];
                r.c  = (full >= lim);
            end
        endcase
        r.n = r.y[N-1];
        r.z = (r.y == '0);
        return r;
    endfunction

    // Transaction-level model: a request completes one edge later, a multiply N edges after acceptance.
    res_t m_res, m_pend;
    logic m_busy, m_done;
    int   m_left;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_res  <= '0;
            m_pend <= '0;
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_left <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_res  <= m_pend;
                end
            end else if (start) begin
                if (op == 3'b111) begin
                    m_pend <= model_op(op, a, b);
                    m_busy <= 1'b1;
                    m_left <= N;
                end else begin
                    m_res  <= model_op(op, a, b);
                    m_done <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        total++;
        if ({y, flag_n, flag_z, flag_c, flag_v, busy, done} !== {m_res, m_busy, m_done}) begin
            bad++;
            $display("FAIL cycle_model t=%0t: got y=%b nzcv=%b%b%b%b busy=%b done=%b, want y=%b nzcv=%b%b%b%b busy=%b done=%b",
                     $time, y, flag_n, flag_z, flag_c, flag_v, busy, done,
                     m_res.y, m_res.n, m_res.z, m_res.c, m_res.v, m_busy, m_done);
        end
    end

    task automatic check_lit(input string name, input logic [N-1:0] ey, input logic [3:0] enzcv,
                             input logic ebusy, input logic edone);
        total++;
        if ({y, flag_n, flag_z, flag_c, flag_v, busy, done} !== {ey, enzcv, ebusy, edone}) begin
            bad++;
            $display("FAIL %s: got y=%b nzcv=%b%b%b%b busy=%b done=%b, want y=%b nzcv=%b busy=%b done=%b",
                     name, y, flag_n, flag_z, flag_c, flag_v, busy, done, ey, enzcv, ebusy, edone);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [N-1:0] x, input logic [N-1:0] w);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = w;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_mul(input logic [N-1:0] x, input logic [N-1:0] w, output int bcnt);
        issue(3'b111, x, w);
        bcnt = 0;
        while (busy && bcnt < 20) begin
            bcnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bc;
        int dcnt;

        repeat (2) @(negedge clk);
        check_lit("reset_state", 4'b0000, 4'b0000, 1'b0, 1'b0);
        #2 rst_n = 1'b1;

        issue(3'b001, 4'b1010, 4'b1100);
        check_lit("or_basic", 4'b1110, 4'b1000, 1'b0, 1'b1);
        @(negedge clk);
        check_lit("or_done_single", 4'b1110, 4'b1000, 1'b0, 1'b0);

        issue(3'b011, 4'b0111, 4'b0001);
        check_lit("add_overflow", 4'b1000, 4'b1001, 1'b0, 1'b1);
        issue(3'b011, 4'b1111, 4'b0001);
        check_lit("add_carry_zero", 4'b0000, 4'b0110, 1'b0, 1'b1);
        issue(3'b100, 4'b0011, 4'b0011);
        check_lit("sub_equal", 4'b0000, 4'b0110, 1'b0, 1'b1);
        issue(3'b100, 4'b0001, 4'b0010);
        check_lit("sub_borrow", 4'b1111, 4'b1000, 1'b0, 1'b1);
        issue(3'b100, 4'b1000, 4'b0001);
        check_lit("sub_overflow", 4'b0111, 4'b0011, 1'b0, 1'b1);
        issue(3'b101, 4'b0001, 4'b0100);
        check_lit("shl_wide", 4'b0000, 4'b0100, 1'b0, 1'b1);

        run_mul(4'b0011, 4'b0101, bc);
        check_int("mul_3x5_busy_cycles", bc, N);
        check_lit("mul_3x5", 4'b1111, 4'b1000, 1'b0, 1'b1);
        run_mul(4'b0110, 4'b0011, bc);
        check_lit("mul_6x3_overflow", 4'b0010, 4'b0010, 1'b0, 1'b1);
        run_mul(4'b1111, 4'b1111, bc);
        check_int("mul_15x15_busy_cycles", bc, N);
        check_lit("mul_15x15", 4'b0001, 4'b0010, 1'b0, 1'b1);

        // A start asserted while busy must be ignored entirely.
        issue(3'b111, 4'b0010, 4'b0010);
        start = 1'b1;
        op    = 3'b001;
        a     = 4'b1111;
        b     = 4'b0000;
        repeat (2) @(negedge clk);
        start = 1'b0;
        dcnt  = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) dcnt++;
            @(negedge clk);
        end
        check_int("busy_reject_done_pulses", dcnt, 1);
        check_lit("busy_reject_result", 4'b0100, 4'b0000, 1'b0, 1'b0);

        // Reset two cycles into a multiply.
        issue(3'b111, 4'b0011, 4'b0011);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_lit("reset_mid_mul", 4'b0000, 4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check_int("reset_no_late_done", dcnt, 0);
        issue(3'b000, 4'b1111, 4'b0101);
        check_lit("and_after_reset", 4'b0101, 4'b0000, 1'b0, 1'b1);

        // Back-to-back single-cycle requests on consecutive edges.
        @(negedge clk);
        start = 1'b1;
        op    = 3'b000;
        a     = 4'b1100;
        b     = 4'b1010;
        @(negedge clk);
        check_lit("b2b_and", 4'b1000, 4'b1000, 1'b0, 1'b1);
        op = 3'b010;
        @(negedge clk);
        check_lit("b2b_xor", 4'b0110, 4'b0000, 1'b0, 1'b1);
        op = 3'b101;
        a  = 4'b0011;
        b  = 4'b0010;
        @(negedge clk);
        check_lit("b2b_shl", 4'b1100, 4'b1000, 1'b0, 1'b1);
        start = 1'b0;
        @(negedge clk);
        check_lit("b2b_hold", 4'b1100, 4'b1000, 1'b0, 1'b0);

        issue(3'b110, 4'b1000, 4'b0100);
        check_lit("shr_wide", 4'b0000, 4'b0100, 1'b0, 1'b1);
        issue(3'b110, 4'b1000, 4'b0010);
        check_lit("shr_two", 4'b0010, 4'b0000, 1'b0, 1'b1);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
